// File: rtl/dut_sequencer_if.sv
// rtl/dut_sequencer_if.sv - stimulus FIFO, result FIFO and DUT pin bundle for dut_sequencer
//
// master: the sequencer (pops stimulus, pushes results, drives mosi, samples miso)
// slave : the environment (FIFOs and DUT pins)
//   sfifo_data/sfifo_rdreq/sfifo_rdempty : show-ahead stimulus FIFO, word = {hold, vector}
//   rfifo_data/rfifo_wrreq/rfifo_wrfull  : result FIFO, word = {index, response}
//   mosi_data/miso_data                  : DUT stimulus / DUT response
interface dut_sequencer_if #(
    parameter int STF_WIDTH   = 24,
    parameter int RTF_WIDTH   = 24,
    parameter int CYCLE_RANGE = 5
);
    logic [STF_WIDTH+CYCLE_RANGE:0] sfifo_data;
    logic                           sfifo_rdreq;
    logic                           sfifo_rdempty;
    logic [RTF_WIDTH+CYCLE_RANGE:0] rfifo_data;
    logic                           rfifo_wrreq;
    logic                           rfifo_wrfull;
    logic [STF_WIDTH-1:0]           mosi_data;
    logic [RTF_WIDTH-1:0]           miso_data;

    modport master (
        input  sfifo_data, sfifo_rdempty, rfifo_wrfull, miso_data,
        output sfifo_rdreq, rfifo_data, rfifo_wrreq, mosi_data
    );

    modport slave (
        output sfifo_data, sfifo_rdempty, rfifo_wrfull, miso_data,
        input  sfifo_rdreq, rfifo_data, rfifo_wrreq, mosi_data
    );
endinterface

// File: rtl/dut_sequencer.sv
// rtl/dut_sequencer.sv - vector engine between stimulus/result FIFOs and the DUT pins
//
// Pops {hold, vector} words, drives each vector on mosi for hold+1 cycles, and
// captures miso after a programmable latency into the result FIFO as {index, miso}.
//   clock, reset_n : single test clock, asynchronous active-low reset
//   enable         : permission to pop new vectors
//   mode           : 0 = one capture per vector, 1 = capture every drive cycle
//   latency        : cycles from drive to valid miso
//   idle           : high only while in IDLE
//   vec_count      : vectors popped since reset (wraps)
//   overflow       : sticky, a capture was dropped because the result FIFO was full
//   bus            : FIFO and DUT pin bundle (master side)
module dut_sequencer #(
    parameter int STF_WIDTH   = 24,
    parameter int RTF_WIDTH   = 24,
    parameter int CYCLE_RANGE = 5,
    parameter int LAT_WIDTH   = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [LAT_WIDTH-1:0] latency,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] vec_count,
    output logic                 overflow,
    dut_sequencer_if.master      bus
);
    localparam int HW    = CYCLE_RANGE + 1;
    localparam int DEPTH = 2 ** LAT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [HW-1:0]        counter;
    logic [HW-1:0]        hold_r;
    logic                 mode_r;
    logic [LAT_WIDTH-1:0] lat_r;

    // Tap k of the capture pipeline is the token issued k cycles ago. Tap 0 is the
    // live token from this cycle, so only taps 1..DEPTH-1 need storage.
    logic [DEPTH-2:0]     pipe_v;
    logic [HW-1:0]        pipe_idx [0:DEPTH-2];

    logic                 can_pop;
    logic                 pop;
    logic                 tok_v;
    logic [HW-1:0]        tok_idx;
    logic                 mat_v;
    logic [HW-1:0]        mat_idx;
    logic                 in_flight;

    assign can_pop         = enable && !bus.sfifo_rdempty && !bus.rfifo_wrfull;
    assign bus.sfifo_rdreq = pop;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tok_v   = 1'b0;
        tok_idx = hold_r;
        case (state)
            S_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_n = S_DRIVE;
                end
            end
            S_DRIVE: begin
                tok_v   = mode_r || (counter == '0);
                tok_idx = mode_r ? (hold_r - counter) : hold_r;
                if (counter == '0) begin
                    if (can_pop) begin
                        pop = 1'b1;
                    end else begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Select the token maturing this cycle. Anything in a stage shallower than
    // the tap still has to mature after this edge, which keeps DRAIN alive.
    always_comb begin
        mat_v     = 1'b0;
        mat_idx   = tok_idx;
        in_flight = 1'b0;
        if (lat_r == '0) begin
            mat_v   = tok_v;
            mat_idx = tok_idx;
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (int'(lat_r) == k + 1) begin
                mat_v   = pipe_v[k];
                mat_idx = pipe_idx[k];
            end
            if ((k + 1 < int'(lat_r)) && pipe_v[k]) begin
                in_flight = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            idle            <= 1'b1;
            counter         <= '0;
            hold_r          <= '0;
            mode_r          <= 1'b0;
            lat_r           <= '0;
            vec_count       <= '0;
            overflow        <= 1'b0;
            bus.mosi_data   <= '0;
            bus.rfifo_data  <= '0;
            bus.rfifo_wrreq <= 1'b0;
        end else begin
            state <= state_n;
            idle  <= (state_n == S_IDLE);

            if (pop) begin
                bus.mosi_data <= bus.sfifo_data[STF_WIDTH-1:0];
                counter       <= bus.sfifo_data[STF_WIDTH+CYCLE_RANGE:STF_WIDTH];
                hold_r        <= bus.sfifo_data[STF_WIDTH+CYCLE_RANGE:STF_WIDTH];
                vec_count     <= vec_count + CNT_WIDTH'(1);
                // Back-to-back pops keep the configuration of the run.
                if (state == S_IDLE) begin
                    mode_r <= mode;
                    lat_r  <= latency;
                end
            end else if (counter != '0) begin
                counter <= counter - HW'(1);
            end

            bus.rfifo_wrreq <= 1'b0;
            if (mat_v) begin
                if (!bus.rfifo_wrfull) begin
                    bus.rfifo_data  <= {mat_idx, bus.miso_data};
                    bus.rfifo_wrreq <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Stages past the tap are dead: clearing them keeps stale tokens from an
    // earlier short-latency run from maturing in a later long-latency run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                pipe_idx[k] <= '0;
            end
        end else begin
            pipe_v[0]   <= tok_v && (lat_r != '0);
            pipe_idx[0] <= tok_idx;
            for (int k = 1; k < DEPTH - 1; k++) begin
                pipe_v[k]   <= pipe_v[k-1] && (k < int'(lat_r));
                pipe_idx[k] <= pipe_idx[k-1];
            end
        end
    end
endmodule

// File: tb/tb_dut_sequencer.sv
// tb/tb_dut_sequencer.sv - self-checking bench for dut_sequencer
module tb_dut_sequencer;
    localparam int STF = 24;
    localparam int RTF = 24;
    localparam int CR  = 5;
    localparam int LW  = 3;
    localparam int CW  = 16;
    localparam int HW  = CR + 1;

    logic           clock   = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable  = 1'b0;
    logic           mode_in = 1'b0;
    logic [LW-1:0]  lat_in  = '0;
    logic           idle;
    logic [CW-1:0]  vec_count;
    logic           overflow;

    dut_sequencer_if #(.STF_WIDTH(STF), .RTF_WIDTH(RTF), .CYCLE_RANGE(CR)) bus ();

    dut_sequencer #(
        .STF_WIDTH(STF), .RTF_WIDTH(RTF), .CYCLE_RANGE(CR),
        .LAT_WIDTH(LW), .CNT_WIDTH(CW)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode      (mode_in),
        .latency   (lat_in),
        .idle      (idle),
        .vec_count (vec_count),
        .overflow  (overflow),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int                   cyc   = 0;
    int                   n_vec = 0;
    int                   n_err = 0;
    logic [STF+HW-1:0]    stim_mem [0:255];
    logic [7:0]           wr_ptr = '0;
    logic [7:0]           rd_ptr = '0;
    logic                 full = 1'b0;
    logic                 miso_sel = 1'b0;
    logic [RTF-1:0]       miso_const = '0;
    int                   lat_loop = 0;
    logic [STF-1:0]       hist [0:7];
    logic [STF-1:0]       mosi_at [0:4095];
    int                   rq[$];
    int                   wq_cyc[$];
    logic [RTF+HW-1:0]    wq_dat[$];
    int                   vc_model = 0;
    logic                 ov_model = 1'b0;
    logic [HW-1:0]        wl_h[$];
    logic [STF-1:0]       wl_v[$];

    // Environment: show-ahead FIFO, full flag, loopback DUT delaying mosi by lat_loop.
    assign bus.sfifo_data    = stim_mem[rd_ptr];
    assign bus.sfifo_rdempty = (rd_ptr == wr_ptr);
    assign bus.rfifo_wrfull  = full;
    assign bus.miso_data     = miso_sel ? miso_const :
                               (lat_loop == 0 ? bus.mosi_data : hist[(lat_loop == 0) ? 0 : lat_loop - 1]);

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        hist[0] <= bus.mosi_data;
        for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
        if (bus.sfifo_rdreq) rd_ptr <= rd_ptr + 8'd1;
        if (bus.rfifo_wrreq) begin
            wq_cyc.push_back(cyc);
            wq_dat.push_back(bus.rfifo_data);
        end
    end

    always @(negedge clock) begin
        mosi_at[cyc % 4096] <= bus.mosi_data;
        if (bus.sfifo_rdreq) rq.push_back(cyc);
    end

    function automatic logic [STF-1:0] rnd_vec();
        logic [31:0] r;
        r = $urandom;
        return r[STF-1:0];
    endfunction

    function automatic logic [HW-1:0] rnd_h(input int hi);
        logic [31:0] r;
        r = $urandom_range(0, hi);
        return r[HW-1:0];
    endfunction

    task automatic load_words();
        for (int j = 0; j < wl_h.size(); j++) begin
            stim_mem[wr_ptr] = {wl_h[j], wl_v[j]};
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    // Runs the loaded word list and checks pops, mosi trace, writes and idle timing
    // against a cycle-accurate schedule derived from hold counts and latency.
    task automatic run_words(input logic m, input int l, input logic use_const,
                             input logic [RTF-1:0] cval, input int drop_rel, input string name);
        int r0, s, t_idle, budget, exp_idle, last_j;
        int e_rq[$];
        int e_cyc[$];
        logic [RTF+HW-1:0] e_dat[$];
        load_words();
        lat_loop = l; miso_sel = use_const; miso_const = cval;
        rq.delete(); wq_cyc.delete(); wq_dat.delete();
        @(posedge clock); #1;
        mode_in = m; lat_in = l[LW-1:0]; enable = 1'b1; r0 = cyc;
        t_idle = -1; budget = 0;
        while (t_idle < 0 && budget < 3000) begin
            @(posedge clock); #1;
            if (cyc == r0 + drop_rel) enable = 1'b0;
            if (cyc == r0 + 2) begin mode_in = ~m; lat_in = ~l[LW-1:0]; end
            @(negedge clock);
            if (idle) t_idle = cyc;
            budget++;
        end
        enable = 1'b0; mode_in = m; lat_in = l[LW-1:0];
        @(posedge clock); #1;

        s = r0 + 1; last_j = -1;
        for (int j = 0; j < wl_h.size(); j++) begin
            if (s - 1 >= r0 + drop_rel) break;
            e_rq.push_back(s - 1);
            last_j = j;
            for (int i = 0; i <= int'(wl_h[j]); i++) begin
                n_vec++;
                if (mosi_at[(s + i) % 4096] !== wl_v[j]) begin
                    n_err++;
                    $display("FAIL %s mosi cycle %0d: got %h want %h", name, s + i, mosi_at[(s + i) % 4096], wl_v[j]);
                end
                if (m || i == int'(wl_h[j])) begin
                    e_cyc.push_back(s + i + l + 1);
                    e_dat.push_back({m ? i[HW-1:0] : wl_h[j], use_const ? cval : wl_v[j]});
                end
            end
            s += int'(wl_h[j]) + 1;
        end
        exp_idle = s + ((l == 0) ? 1 : l);
        vc_model += e_rq.size();

        n_vec++;
        if (last_j >= 0 && mosi_at[s % 4096] !== wl_v[last_j]) begin
            n_err++;
            $display("FAIL %s mosi hold: got %h want %h", name, mosi_at[s % 4096], wl_v[last_j]);
        end
        n_vec++;
        if (t_idle != exp_idle) begin
            n_err++;
            $display("FAIL %s idle cycle: got %0d want %0d", name, t_idle, exp_idle);
        end
        n_vec++;
        if (rq.size() != e_rq.size()) begin
            n_err++;
            $display("FAIL %s pop count: got %0d want %0d", name, rq.size(), e_rq.size());
        end else begin
            for (int j = 0; j < rq.size(); j++) begin
                n_vec++;
                if (rq[j] != e_rq[j]) begin
                    n_err++;
                    $display("FAIL %s pop %0d cycle: got %0d want %0d", name, j, rq[j], e_rq[j]);
                end
            end
        end
        n_vec++;
        if (wq_cyc.size() != e_cyc.size()) begin
            n_err++;
            $display("FAIL %s write count: got %0d want %0d", name, wq_cyc.size(), e_cyc.size());
        end else begin
            for (int j = 0; j < wq_cyc.size(); j++) begin
                n_vec++;
                if (wq_cyc[j] != e_cyc[j] || wq_dat[j] !== e_dat[j]) begin
                    n_err++;
                    $display("FAIL %s write %0d: got cyc %0d data %h want cyc %0d data %h",
                             name, j, wq_cyc[j], wq_dat[j], e_cyc[j], e_dat[j]);
                end
            end
        end
        n_vec++;
        if (vec_count !== vc_model[CW-1:0]) begin
            n_err++;
            $display("FAIL %s vec_count: got %0d want %0d", name, vec_count, vc_model[CW-1:0]);
        end
        n_vec++;
        if (overflow !== ov_model) begin
            n_err++;
            $display("FAIL %s overflow: got %b want %b", name, overflow, ov_model);
        end
        wr_ptr = rd_ptr;
        wl_h.delete(); wl_v.delete();
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_vec++;
        if (idle !== 1'b1 || vec_count !== '0 || overflow !== 1'b0 || bus.mosi_data !== '0 ||
            bus.rfifo_data !== '0 || bus.rfifo_wrreq !== 1'b0 || bus.sfifo_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL reset values: got idle=%b cnt=%0d ovf=%b mosi=%h rdata=%h wr=%b rd=%b want 1 0 0 0 0 0 0",
                     idle, vec_count, overflow, bus.mosi_data, bus.rfifo_data, bus.rfifo_wrreq, bus.sfifo_rdreq);
        end
    endtask

    task automatic test_single();
        wl_h.push_back(6'd3); wl_v.push_back(24'hA5A5A5);
        run_words(1'b0, 0, 1'b1, 24'h123456, 1000, "single");
    endtask

    task automatic test_loopback();
        wl_h.push_back(6'd2); wl_v.push_back(rnd_vec());
        run_words(1'b1, 2, 1'b0, '0, 1000, "loopback");
    endtask

    task automatic test_back_to_back();
        for (int j = 1; j <= 3; j++) begin
            wl_h.push_back('0); wl_v.push_back(j[STF-1:0]);
        end
        run_words(1'b0, 0, 1'b0, '0, 1000, "back_to_back");
    endtask

    task automatic test_random();
        logic [31:0] r;
        int n;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin
                wl_h.push_back(6'd63); wl_v.push_back(rnd_vec());
                run_words(1'b1, 7, 1'b0, '0, 1000, "rand_h63");
            end else begin
                n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) begin
                    wl_h.push_back(rnd_h(4)); wl_v.push_back(rnd_vec());
                end
                r = $urandom;
                run_words(r[0], $urandom_range(0, 7), 1'b0, '0, 1000, "random");
            end
        end
    endtask

    task automatic test_full();
        int r0, s, bad, mat;
        int e_cyc[$];
        logic [RTF+HW-1:0] e_dat[$];
        logic [STF-1:0] v;
        v = rnd_vec();
        stim_mem[wr_ptr] = {6'd4, v}; wr_ptr = wr_ptr + 8'd1;
        lat_loop = 1; miso_sel = 1'b0;
        rq.delete(); wq_cyc.delete(); wq_dat.delete();
        @(posedge clock); #1;
        full = 1'b1; mode_in = 1'b1; lat_in = 3'd1; enable = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.sfifo_rdreq !== 1'b0 || idle !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL full_blocks_pop: got %0d bad cycles want 0", bad);
        end
        @(posedge clock); #1;
        full = 1'b0; r0 = cyc;
        @(negedge clock);
        n_vec++;
        if (bus.sfifo_rdreq !== 1'b1) begin
            n_err++;
            $display("FAIL full_release_pop: got rdreq %b want 1", bus.sfifo_rdreq);
        end
        s = r0 + 1;
        while (cyc < r0 + 12) begin
            @(posedge clock); #1;
            full = (cyc == s + 2) || (cyc == s + 3);
        end
        full = 1'b0; enable = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            mat = s + i + 1;
            if (mat == s + 2 || mat == s + 3) ov_model = 1'b1;
            else begin
                e_cyc.push_back(mat + 1);
                e_dat.push_back({i[HW-1:0], v});
            end
        end
        vc_model++;
        n_vec++;
        if (wq_cyc.size() != e_cyc.size()) begin
            n_err++;
            $display("FAIL full write count: got %0d want %0d", wq_cyc.size(), e_cyc.size());
        end else begin
            for (int j = 0; j < wq_cyc.size(); j++) begin
                n_vec++;
                if (wq_cyc[j] != e_cyc[j] || wq_dat[j] !== e_dat[j]) begin
                    n_err++;
                    $display("FAIL full write %0d: got cyc %0d data %h want cyc %0d data %h",
                             j, wq_cyc[j], wq_dat[j], e_cyc[j], e_dat[j]);
                end
            end
        end
        n_vec++;
        if (overflow !== ov_model) begin
            n_err++;
            $display("FAIL full overflow: got %b want %b", overflow, ov_model);
        end
        repeat (10) @(posedge clock);
        #1;
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow sticky: got %b want 1", overflow);
        end
        n_vec++;
        if (vec_count !== vc_model[CW-1:0]) begin
            n_err++;
            $display("FAIL full vec_count: got %0d want %0d", vec_count, vc_model[CW-1:0]);
        end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_enable_drop();
        wl_h.push_back(6'd5); wl_v.push_back(rnd_vec());
        wl_h.push_back(6'd1); wl_v.push_back(rnd_vec());
        run_words(1'b0, 2, 1'b0, '0, 2, "enable_drop");
    endtask

    task automatic test_empty_idle();
        int bad;
        rq.delete();
        @(posedge clock); #1;
        enable = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (idle !== 1'b1) bad++;
        end
        enable = 1'b0;
        n_vec++;
        if (bad != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL empty_idle: got %0d non-idle cycles %0d pops want 0 0", bad, rq.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [STF-1:0] v;
        v = rnd_vec() | 24'h000001;
        stim_mem[wr_ptr] = {6'd20, v}; wr_ptr = wr_ptr + 8'd1;
        lat_loop = 3; miso_sel = 1'b0;
        @(posedge clock); #1;
        mode_in = 1'b1; lat_in = 3'd3; enable = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        reset_n = 1'b0; enable = 1'b0;
        #1;
        n_vec++;
        if (idle !== 1'b1 || vec_count !== '0 || overflow !== 1'b0 || bus.mosi_data !== '0 ||
            bus.rfifo_data !== '0 || bus.rfifo_wrreq !== 1'b0) begin
            n_err++;
            $display("FAIL async reset: got idle=%b cnt=%0d ovf=%b mosi=%h rdata=%h wr=%b want 1 0 0 0 0 0",
                     idle, vec_count, overflow, bus.mosi_data, bus.rfifo_data, bus.rfifo_wrreq);
        end
        wr_ptr = rd_ptr;
        wq_cyc.delete(); wq_dat.delete();
        vc_model = 0; ov_model = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        n_vec++;
        if (wq_cyc.size() != 0 || idle !== 1'b1 || vec_count !== '0) begin
            n_err++;
            $display("FAIL after reset: got %0d writes idle=%b cnt=%0d want 0 1 0", wq_cyc.size(), idle, vec_count);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_random();
        test_full();
        test_enable_drop();
        test_empty_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
